// File: rtl/adsb_tx_if.sv
// rtl/adsb_tx_if.sv - frame request and modulator output bundle for adsb_tx
interface adsb_tx_if #(
  parameter int width = 10
);
  logic             start;
  logic             long_frame;
  logic [111:0]     frame;
  logic             busy;
  logic             pulse;
  logic [width-1:0] mag;
  logic             bit_ena;
  logic             tx_bit;
  logic             done;

  modport master (
    output start, long_frame, frame,
    input  busy, pulse, mag, bit_ena, tx_bit, done
  );

  modport slave (
    input  start, long_frame, frame,
    output busy, pulse, mag, bit_ena, tx_bit, done
  );
endinterface

// File: rtl/adsb_tx.sv
// rtl/adsb_tx.sv - ADS-B Mode S extended-squitter PPM modulator (preamble, PPM data, guard)
module adsb_tx #(
  parameter int               width     = 10,
  parameter int               spc       = 4,
  parameter logic [width-1:0] on_level  = width'('h3C0),
  parameter logic [width-1:0] off_level = width'('h040),
  parameter int               guard     = 8
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     ena,
  adsb_tx_if.slave tx
);

  typedef enum logic [1:0] {s_idle, s_pre, s_data, s_guard} state_t;

  localparam logic [4:0]  samp_last  = 5'(spc - 1);
  localparam logic [7:0]  guard_last = 8'((guard > 0) ? guard - 1 : 0);
  // Preamble pulses sit on chips 0, 2, 7 and 9.
  localparam logic [15:0] pre_mask   = 16'h0285;

  state_t       state;
  logic [4:0]   samp;
  logic [7:0]   chip;
  logic [111:0] shreg;
  logic         long_q;
  logic         chip_end;
  logic         pre_next;
  logic [7:0]   data_last;

  assign chip_end  = ena && (samp == samp_last);
  assign pre_next  = pre_mask[4'(chip[3:0] + 4'd1)];
  assign data_last = long_q ? 8'd223 : 8'd111;

  function automatic logic [width-1:0] level(input logic p);
    return p ? on_level : off_level;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= s_idle;
      samp       <= '0;
      chip       <= '0;
      shreg      <= '0;
      long_q     <= 1'b0;
      tx.busy    <= 1'b0;
      tx.pulse   <= 1'b0;
      tx.mag     <= off_level;
      tx.bit_ena <= 1'b0;
      tx.tx_bit  <= 1'b0;
      tx.done    <= 1'b0;
    end else begin
      tx.bit_ena <= 1'b0;
      tx.done    <= 1'b0;
      if (ena && state != s_idle) begin
        samp <= chip_end ? 5'd0 : samp + 5'd1;
      end
      case (state)
        s_idle: begin
          // The clock that reports done must not also accept a new frame.
          if (tx.start && !tx.done) begin
            shreg    <= tx.frame;
            long_q   <= tx.long_frame;
            samp     <= '0;
            chip     <= '0;
            state    <= s_pre;
            tx.busy  <= 1'b1;
            tx.pulse <= 1'b1;
            tx.mag   <= on_level;
          end
        end
        s_pre: begin
          if (chip_end) begin
            if (chip == 8'd15) begin
              state      <= s_data;
              chip       <= '0;
              tx.pulse   <= shreg[111];
              tx.mag     <= level(shreg[111]);
              tx.bit_ena <= 1'b1;
              tx.tx_bit  <= shreg[111];
            end else begin
              chip     <= chip + 8'd1;
              tx.pulse <= pre_next;
              tx.mag   <= level(pre_next);
            end
          end
        end
        s_data: begin
          if (chip_end) begin
            if (!chip[0]) begin
              chip     <= chip + 8'd1;
              tx.pulse <= ~shreg[111];
              tx.mag   <= level(~shreg[111]);
            end else if (chip == data_last) begin
              tx.pulse <= 1'b0;
              tx.mag   <= off_level;
              chip     <= '0;
              if (guard == 0) begin
                state   <= s_idle;
                tx.busy <= 1'b0;
                tx.done <= 1'b1;
              end else begin
                state <= s_guard;
              end
            end else begin
              // Next bit sits one below the MSB until the shift lands.
              shreg      <= {shreg[110:0], 1'b0};
              chip       <= chip + 8'd1;
              tx.pulse   <= shreg[110];
              tx.mag     <= level(shreg[110]);
              tx.bit_ena <= 1'b1;
              tx.tx_bit  <= shreg[110];
            end
          end
        end
        s_guard: begin
          if (chip_end) begin
            if (chip == guard_last) begin
              state   <= s_idle;
              chip    <= '0;
              tx.busy <= 1'b0;
              tx.done <= 1'b1;
            end else begin
              chip <= chip + 8'd1;
            end
          end
        end
      endcase
    end
  end

endmodule
